// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined WIDTH-bit adder/subtractor with carry chaining,
// NZCV-style flags and a valid/ready handshake on both sides.
//
// Stage 1 captures the combinational sum, flags and (optionally) the
// saturated result. Stages 2..STAGES are plain register copies, each with
// its own valid bit. Bubbles collapse: a stage loads whenever it is empty
// or its content is moving on in the same cycle.
//
// Optional feature macro: ADDSUB_PIPE_SAT_EN
//   defined   -> in_sat = 1 clamps a signed overflow to the most-positive
//                or most-negative value
//   undefined -> in_sat is ignored and out_s is always the wrapped sum
//
// Parameters: WIDTH 4..64 (multiple of 4), STAGES 1..4.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_sub,
  input  logic             in_use_cin,
  input  logic             in_cin,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n
);

  // Payload layout: {s, c, v, z, n}
  localparam int PW = WIDTH + 4;

  logic [WIDTH-1:0] y_eff;
  logic             cin_eff;
  logic [WIDTH:0]   sum_w;
  logic             ovf_w;
  logic [WIDTH-1:0] res_w;
  logic [PW-1:0]    pld_new;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] load;
  logic [PW-1:0]     pld_q [STAGES];
  logic [PW-1:0]     pld_d [STAGES];
  logic              rdy_q, rdy_d;
  logic              in_fire;

`ifdef ADDSUB_PIPE_SAT_EN
`else
  // in_sat has no effect in the wrapping-only build.
  logic unused_sat;
  assign unused_sat = in_sat;
`endif

  // Datapath: SUB is X + ~Y + 1, or X + ~Y + cin when the carry is chained.
  always_comb begin
    y_eff   = in_sub ? ~in_y : in_y;
    cin_eff = in_use_cin ? in_cin : in_sub;
    sum_w   = {1'b0, in_x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, cin_eff};
    // Overflow: the two addends agree in sign and the result does not.
    ovf_w   = (in_x[WIDTH-1] == y_eff[WIDTH-1]) &&
              (sum_w[WIDTH-1] != in_x[WIDTH-1]);
    res_w   = sum_w[WIDTH-1:0];
`ifdef ADDSUB_PIPE_SAT_EN
    // Both addends share the sign of in_x when overflowing, so it picks the rail.
    if (in_sat && ovf_w) begin
      res_w = in_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    pld_new = {res_w, sum_w[WIDTH], ovf_w, (res_w == '0), res_w[WIDTH-1]};
  end

  // A stage is blocked only when it and every stage after it are full and the
  // output is stalled; otherwise it may load (bubble collapsing).
  always_comb begin
    logic full_from;
    full_from = 1'b1;
    load      = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_from = full_from & vld_q[k];
      load[k]   = !(full_from && !out_ready);
    end
  end

  // in_ready is gated by a flop cleared in reset so it is low during reset
  // and rises on the first clock after release.
  assign in_ready = rdy_q && load[0];
  assign in_fire  = in_valid && in_ready;

  // Next-state for valid bits and payloads: load from upstream or hold.
  always_comb begin
    rdy_d = 1'b1;
    vld_d = vld_q;
    for (int k = 0; k < STAGES; k++) begin
      pld_d[k] = pld_q[k];
    end

    if (load[0]) begin
      vld_d[0] = in_valid && rdy_q;
    end
    if (in_fire) begin
      pld_d[0] = pld_new;
    end

    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          pld_d[k] = pld_q[k-1];
        end
      end
    end
  end

  // Pipeline registers; reset drops every in-flight result immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      rdy_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        pld_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      rdy_q <= rdy_d;
      for (int k = 0; k < STAGES; k++) begin
        pld_q[k] <= pld_d[k];
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_s     = pld_q[STAGES-1][PW-1:4];
  assign out_c     = pld_q[STAGES-1][3];
  assign out_v     = pld_q[STAGES-1][2];
  assign out_z     = pld_q[STAGES-1][1];
  assign out_n     = pld_q[STAGES-1][0];

endmodule
